// File: rtl/cas_fsk_player.sv
// Cassette FSK player: plays one byte per handshake as a tape frame (optional
// 2400 Hz header, start bit, 8 data bits LSB first, two stop bits) on cas_o.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a byte; cas_o low, ready_o when motor is on
// S_HDR   | emitting header cycles at the 2400 Hz half-period
// S_START | emitting the start bit (a 0 bit)
// S_DATA  | emitting data bits 0..7, bit_q = data bit index + 1
// S_STOP  | emitting the two stop bits (1 bits), bit_q = 9 or 10
module cas_fsk_player #(
  parameter int HALF_2400 = 746,
  parameter int HALF_1200 = 1492,
  parameter int SHORT_HDR = 4000,
  parameter int LONG_HDR  = 16000
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       ce_i,
  input  logic       motor_i,
  input  logic [7:0] data_i,
  input  logic [1:0] hdr_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       cas_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  localparam logic [10:0] H24_LD   = 11'(HALF_2400 - 1);
  localparam logic [10:0] H12_LD   = 11'(HALF_1200 - 1);
  localparam logic [13:0] SHORT_LD = 14'(SHORT_HDR - 1);
  localparam logic [13:0] LONG_LD  = 14'(LONG_HDR - 1);

  state_t      state_q, state_d;
  logic        cas_q, cas_d;
  logic [10:0] half_q, half_d;
  logic [13:0] cyc_q, cyc_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        run_q;

  logic        cur_bit;
  logic [10:0] cur_ld;
  state_t      adv_state;
  logic [3:0]  adv_bit;
  logic        adv_val;

  assign ready_o = run_q & (state_q == S_IDLE) & motor_i;
  assign busy_o  = (state_q != S_IDLE);
  assign cas_o   = cas_q;

  // Value of the bit being sent now; header cycles use the 2400 Hz length like a 1 bit.
  always_comb begin
    cur_bit = 1'b1;
    case (state_q)
      S_START: cur_bit = 1'b0;
      S_DATA:  cur_bit = data_q[3'(bit_q - 4'd1)];
      default: cur_bit = 1'b1;
    endcase
    cur_ld = cur_bit ? H24_LD : H12_LD;
  end

  // Which unit follows the current one once its last tone cycle ends.
  always_comb begin
    adv_state = state_q;
    adv_bit   = bit_q;
    adv_val   = 1'b1;
    case (state_q)
      S_HDR: begin
        adv_state = S_START;
        adv_bit   = 4'd0;
        adv_val   = 1'b0;
      end
      S_START: begin
        adv_state = S_DATA;
        adv_bit   = 4'd1;
        adv_val   = data_q[0];
      end
      S_DATA: begin
        if (bit_q == 4'd8) begin
          adv_state = S_STOP;
          adv_bit   = 4'd9;
          adv_val   = 1'b1;
        end else begin
          adv_state = S_DATA;
          adv_bit   = bit_q + 4'd1;
          adv_val   = data_q[bit_q[2:0]];
        end
      end
      S_STOP: begin
        if (bit_q == 4'd10) begin
          adv_state = S_IDLE;
        end else begin
          adv_state = S_STOP;
          adv_bit   = 4'd10;
        end
      end
      default: adv_state = S_IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cas_d   = cas_q;
    half_d  = half_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    data_d  = data_q;
    if (state_q == S_IDLE) begin
      cas_d = 1'b0;
      if (valid_i && ready_o) begin
        data_d = data_i;
        bit_d  = 4'd0;
        if (hdr_i != 2'b00) begin
          state_d = S_HDR;
          cyc_d   = (hdr_i == 2'b01) ? SHORT_LD : LONG_LD;
          half_d  = H24_LD;
        end else begin
          state_d = S_START;
          cyc_d   = 14'd0;
          half_d  = H12_LD;
        end
      end
    end else if (motor_i && ce_i) begin
      // Motor off freezes everything; a ce tick only counts with the motor running.
      if (half_q != 11'd0) begin
        half_d = half_q - 11'd1;
      end else begin
        cas_d = ~cas_q;
        if (!cas_q) begin
          half_d = cur_ld;
        end else if (cyc_q != 14'd0) begin
          cyc_d  = cyc_q - 14'd1;
          half_d = cur_ld;
        end else begin
          state_d = adv_state;
          bit_d   = adv_bit;
          cyc_d   = adv_val ? 14'd1 : 14'd0;
          half_d  = adv_val ? H24_LD : H12_LD;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cas_q   <= 1'b0;
      half_q  <= 11'd0;
      cyc_q   <= 14'd0;
      bit_q   <= 4'd0;
      data_q  <= 8'h00;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cas_q   <= cas_d;
      half_q  <= half_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      run_q   <= 1'b1;
    end
  end

endmodule
